// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU writes hit the register-file port 1 edge after valid, load results 2+ edges after push.
// Backpressure: ld_ready drops when the FIFO is full; alu_stall forces one load drain after STARVE_LIMIT losses.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [4:0]                   alu_rd,
    input  logic [31:0]                  alu_data,
    output logic                         alu_stall,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [4:0]                   ld_rd,
    input  logic [31:0]                  ld_data,
    output logic [4:0]                   a3,
    output logic                         we3,
    output logic [31:0]                  wd3,
    input  logic [4:0]                   q_addr,
    output logic                         q_pending,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [SW-1:0] LIM  = SW'(STARVE_LIMIT);

    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_we3;
    logic [4:0]    r_a3;
    logic [31:0]   r_wd3;
    logic          r_proto_err;

    logic          w_fifo_ne;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_alu_win;
    logic          w_q_hit;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_off;

    assign w_fifo_ne  = (r_count != '0);
    assign ld_ready   = (r_count != FULL);
    assign alu_stall  = (r_starve == LIM) && w_fifo_ne;
    assign w_accept   = ld_valid && ld_ready;
    // rd==0 loads complete the handshake but are never stored
    assign w_push     = w_accept && (ld_rd != 5'd0);
    assign w_alu_win  = alu_valid && !alu_stall;
    assign w_pop      = alu_stall || (!alu_valid && w_fifo_ne);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= ld_rd;
            r_mem_data[r_wptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_we3       <= 1'b0;
            r_a3        <= 5'd0;
            r_wd3       <= 32'd0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end

            if (w_pop || !w_fifo_ne) begin
                r_starve <= '0;
            end else if (w_alu_win && (r_starve != LIM)) begin
                r_starve <= r_starve + 1'b1;
            end

            if (w_pop) begin
                r_we3 <= 1'b1;
                r_a3  <= r_mem_rd[r_rptr];
                r_wd3 <= r_mem_data[r_rptr];
            end else if (w_alu_win) begin
                r_we3 <= (alu_rd != 5'd0);
                r_a3  <= alu_rd;
                r_wd3 <= alu_data;
            end else begin
                r_we3 <= 1'b0;
            end

            if (alu_valid && alu_stall) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy
    always_comb begin
        w_q_hit = 1'b0;
        w_idx   = '0;
        w_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = AW'(i);
            w_off = w_idx - r_rptr;
            if ((CW'(w_off) < r_count) && (r_mem_rd[w_idx] == q_addr)) begin
                w_q_hit = 1'b1;
            end
        end
    end

    assign q_pending  = (q_addr != 5'd0) && ((r_we3 && (r_a3 == q_addr)) || w_q_hit);
    assign a3         = r_a3;
    assign we3        = r_we3;
    assign wd3        = r_wd3;
    assign fifo_count = r_count;
    assign proto_err  = r_proto_err;

endmodule
